mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the 64-bit RISC-V pipeline, directly upstream of writeback data selection. Takes one load/store/non-memory op from execute, runs it over the data bus with a valid/data_ok handshake, and aligns and sign- or zero-extends load data. Hands writeback a registered `mem_rdata`, plus the op, under a valid/ready handshake. One transaction in flight at most.

## Interface
Parameters:
- none; widths come from `common` (`u64` = 64 bits, `op_t`).

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  execute presents an op
- `in_ready`  out  1  stage accepts; high only in IDLE
- `in_op`  in  op_t  operation
- `in_addr`  in  u64  effective address (alu_out)
- `in_wdata`  in  u64  store data (rs2)
- `out_valid`  out  1  result held for writeback
- `out_ready`  in  1  writeback consumes result
- `out_op`  out  op_t  op of the held result
- `mem_rdata`  out  u64  aligned and extended load data; 0 for non-loads
- `misalign`  out  1  held op was misaligned; bus not accessed
- `dreq_valid`  out  1  data-bus request
- `dreq_addr`  out  u64  request address, passed unmodified
- `dreq_size`  out  3  msize: 0=1B, 1=2B, 2=4B, 3=8B
- `dreq_strobe`  out  8  byte write enables; 0 for loads
- `dreq_data`  out  u64  store data shifted into the addressed byte lanes
- `dresp_data_ok`  in  1  bus completes the request this cycle
- `dresp_data`  in  u64  raw 8-byte-aligned read data, valid with `data_ok`

## Operation
- FSM states: IDLE, REQ, DONE. Reset (`resetn`=0 at an edge) forces IDLE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`, latch op, addr and wdata.
  - Aligned load/store: go to REQ.
  - Misaligned load/store or non-memory op: go to DONE with `mem_rdata`=0. `misalign` is set only for misaligned memory ops.
- REQ
  - `dreq_valid`=1, with all dreq fields stable from the latched op.
  - On `dresp_data_ok`: capture the aligned/extended result and go to DONE.
- DONE
  - `out_valid`=1.
  - On `out_ready`: go to IDLE.
- Alignment rules:
  - D requires `addr[2:0]`=0.
  - W/WU requires `addr[1:0]`=0.
  - H/HU requires `addr[0]`=0.
  - B is always aligned.
- Load path: `sh = dresp_data >> (8*addr[2:0])`.
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD passes through.
- Store path:
  - Strobe: SB `8'h01<<a`, SH `8'h03<<a`, SW `8'h0F<<a`, SD `8'hFF`, where `a` = `addr[2:0]`.
  - `dreq_data = in_wdata << (8*a)`.
- Reset values:
  - `in_ready`=1 (IDLE).
  - `out_valid`=0, `dreq_valid`=0.
  - `mem_rdata`=0, `misalign`=0, `out_op`=OP_NOP.
  - All dreq fields 0.
- Reset mid-REQ: the request is dropped and `dreq_valid`=0 the next cycle. The bus owner tolerates abandoned requests. A late `data_ok` while not in REQ is ignored.

## Timing
- `in_ready`, `out_valid` and `dreq_valid` are decoded from state only. There are no combinational in→out paths.
- Aligned memory op:
  - Accepted at edge 0, so `dreq_valid`=1 in cycle 1.
  - `data_ok` in cycle k≥1 gives `out_valid`=1 in cycle k+1.
  - Minimum accept-to-out latency: 2 cycles.
- Non-memory or misaligned op: `out_valid` in the cycle after acceptance (1 cycle).
- The next op is accepted no earlier than the cycle after the `out_valid` & `out_ready` edge (IDLE).
- `out_*` hold stable while `out_valid` & !`out_ready`.

## Structure
- Add to package `common`:
  - `op_t` members OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_SB, OP_SH, OP_SW, OP_SD, OP_NOP (OP_LD already exists).
  - `msize_t` with constants MSIZE1/2/4/8.
  - State enum `mem_state_t`.
- One combinational sub-module, `mem_align`: op + addr[2:0] + wdata + rdata → size, strobe, shifted store data, extended load data, misalign. `mem_access` holds the FSM and registers.

## Test plan
- LW addr `0x…1004`, `dresp_data`=`0x80000000_00000000`, `data_ok` 3 cycles after `dreq_valid` → `dreq_size`=2, strobe 0, `mem_rdata`=`0xFFFFFFFF_80000000`, `out_valid` exactly 1 cycle after `data_ok`.
- LBU addr `0x…0007`, `dresp_data`=`0xAB00…00`, immediate `data_ok` → `mem_rdata`=`0x00000000_000000AB`, 2-cycle latency.
- SH addr `0x…0006`, wdata `0x1234` → strobe `0xC0`, `dreq_data`=`0x1234_0000_0000_0000`, size 1, `mem_rdata`=0.
- LD addr `0x…0004` → `dreq_valid` never asserts, `out_valid` next cycle with `misalign`=1, `mem_rdata`=0.
- `out_ready` held low 5 cycles after an LD result → outputs stable and `in_ready`=0 throughout; `out_ready`=1 → IDLE next cycle.
- `resetn`=0 during REQ → next cycle `dreq_valid`=0, `in_ready`=1, `out_valid`=0; a stray `data_ok` afterwards produces no output.

Source files
------------

// File: rtl/common.sv
// ============================================================================
//  Module   : common (package)
//  Brief    : Shared types for the 64-bit pipeline: operand width, memory op
//             codes, bus access sizes, memory-stage state encoding and the
//             op classification helpers used by the memory-access stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package common;

  typedef logic [63:0] u64;

  // Operation presented to the memory stage; OP_NOP/OP_ALU never touch the bus.
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ALU = 4'd1,
    OP_LB  = 4'd2,
    OP_LH  = 4'd3,
    OP_LW  = 4'd4,
    OP_LD  = 4'd5,
    OP_LBU = 4'd6,
    OP_LHU = 4'd7,
    OP_LWU = 4'd8,
    OP_SB  = 4'd9,
    OP_SH  = 4'd10,
    OP_SW  = 4'd11,
    OP_SD  = 4'd12
  } op_t;

  // Bus access size, encoded as log2(bytes).
  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // True for any load or store.
  function automatic logic op_is_mem(op_t op);
    logic r;
    r = 1'b0;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
      OP_SB, OP_SH, OP_SW, OP_SD: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  // Access size of a memory op; non-memory ops report the 1-byte code.
  function automatic msize_t op_size(op_t op);
    msize_t r;
    r = MSIZE1;
    case (op)
      OP_LH, OP_LHU, OP_SH: r = MSIZE2;
      OP_LW, OP_LWU, OP_SW: r = MSIZE4;
      OP_LD, OP_SD:         r = MSIZE8;
      default:              r = MSIZE1;
    endcase
    return r;
  endfunction

  // Natural alignment check on the low address bits; byte ops never fault.
  function automatic logic op_misaligned(op_t op, logic [2:0] a);
    logic r;
    r = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: r = a[0];
      OP_LW, OP_LWU, OP_SW: r = |a[1:0];
      OP_LD, OP_SD:         r = |a;
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
//  Module   : mem_align
//  Brief    : Combinational lane steering for the memory stage. Produces the
//             bus size, write strobes and shifted store data for an op, and
//             the aligned, sign/zero-extended result of a load.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_align
  import common::*;
(
  input  op_t         op,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [2:0]  size,
  output logic [7:0]  strobe,
  output logic [63:0] sdata,
  output logic [63:0] ldata,
  output logic        misalign
);

  logic [5:0]  w_shamt;
  logic [63:0] w_sh;

  assign w_shamt = {addr_lo, 3'b000};
  assign w_sh    = rdata >> w_shamt;

  // Size, alignment, strobes and store-lane shift.
  always_comb begin
    size     = op_size(op);
    misalign = op_misaligned(op, addr_lo);
    sdata    = wdata << w_shamt;
    strobe   = 8'h00;
    case (op)
      OP_SB:   strobe = 8'h01 << addr_lo;
      OP_SH:   strobe = 8'h03 << addr_lo;
      OP_SW:   strobe = 8'h0F << addr_lo;
      OP_SD:   strobe = 8'hFF;
      default: strobe = 8'h00;
    endcase
  end

  // Load result extension; anything that is not a load yields zero.
  always_comb begin
    ldata = 64'd0;
    case (op)
      OP_LB:   ldata = {{56{w_sh[7]}},  w_sh[7:0]};
      OP_LH:   ldata = {{48{w_sh[15]}}, w_sh[15:0]};
      OP_LW:   ldata = {{32{w_sh[31]}}, w_sh[31:0]};
      OP_LD:   ldata = w_sh;
      OP_LBU:  ldata = {56'd0, w_sh[7:0]};
      OP_LHU:  ldata = {48'd0, w_sh[15:0]};
      OP_LWU:  ldata = {32'd0, w_sh[31:0]};
      default: ldata = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
//  Module   : mem_access
//  Brief    : Memory-access pipeline stage. Accepts one op from execute, runs
//             it over the data bus with a valid/data_ok handshake, and holds
//             the aligned/extended result for writeback under valid/ready.
//             At most one transaction is in flight.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access
  import common::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  op_t         in_op,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output op_t         out_op,
  output logic [63:0] mem_rdata,
  output logic        misalign,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  mem_state_t  r_state;
  mem_state_t  w_next;

  op_t         r_op;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_sdata;
  logic [63:0] r_rdata;
  logic        r_misalign;

  // The aligner sees the incoming op while idle (to register bus fields and
  // decide alignment at accept) and the latched op afterwards (to extend the
  // returning load data). Every output below is registered or state-decoded,
  // so no input reaches an output combinationally.
  op_t         w_a_op;
  logic [2:0]  w_a_lo;
  logic [2:0]  w_size;
  logic [7:0]  w_strobe;
  logic [63:0] w_sdata;
  logic [63:0] w_ldata;
  logic        w_misalign;
  logic        w_accept;
  logic        w_capture;

  assign w_a_op    = (r_state == ST_IDLE) ? in_op        : r_op;
  assign w_a_lo    = (r_state == ST_IDLE) ? in_addr[2:0] : r_addr[2:0];
  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_capture = (r_state == ST_REQ)  && dresp_data_ok;

  mem_align u_align (
    .op       (w_a_op),
    .addr_lo  (w_a_lo),
    .wdata    (in_wdata),
    .rdata    (dresp_data),
    .size     (w_size),
    .strobe   (w_strobe),
    .sdata    (w_sdata),
    .ldata    (w_ldata),
    .misalign (w_misalign)
  );

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and handshake decode, driven from state only.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    dreq_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op_is_mem(in_op) && !w_misalign) w_next = ST_REQ;
          else                                 w_next = ST_DONE;
        end
      end
      ST_REQ: begin
        dreq_valid = 1'b1;
        if (dresp_data_ok) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch the op and bus fields at accept; capture load data on completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op       <= OP_NOP;
      r_addr     <= 64'd0;
      r_size     <= 3'd0;
      r_strobe   <= 8'd0;
      r_sdata    <= 64'd0;
      r_rdata    <= 64'd0;
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_op       <= in_op;
      r_addr     <= in_addr;
      r_size     <= w_size;
      r_strobe   <= w_strobe;
      r_sdata    <= w_sdata;
      r_rdata    <= 64'd0;
      r_misalign <= w_misalign;
    end else if (w_capture) begin
      r_rdata    <= w_ldata;
    end
  end

  assign out_op      = r_op;
  assign mem_rdata   = r_rdata;
  assign misalign    = r_misalign;
  assign dreq_addr   = r_addr;
  assign dreq_size   = r_size;
  assign dreq_strobe = r_strobe;
  assign dreq_data   = r_sdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
//  Module   : tb_mem_access
//  Brief    : Self-checking bench for mem_access: a table of ops applied in a
//             loop with expected results queued at accept and compared when
//             writeback consumes them, plus reset and back-pressure sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access;
  import common::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  op_t         in_op;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  op_t         out_op;
  logic [63:0] mem_rdata;
  logic        misalign;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    op_t         op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          delay;
    int          hold;
    logic        bus;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] ddata;
    logic [63:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    op_t         op;
    logic [63:0] rdata;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mem_access dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op        (out_op),
    .mem_rdata     (mem_rdata),
    .misalign      (misalign),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(op_t op, logic [63:0] addr, logic [63:0] wdata,
                              logic [63:0] rdata, int delay, int hold, logic bus,
                              logic [2:0] size, logic [7:0] strobe,
                              logic [63:0] ddata, logic [63:0] exp_rdata,
                              logic exp_mis);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.delay = delay; v.hold = hold; v.bus = bus; v.size = size;
    v.strobe = strobe; v.ddata = ddata; v.exp_rdata = exp_rdata;
    v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = v.op; in_addr = v.addr; in_wdata = v.wdata;
    step();
    in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_wdata = '0;
    e.op = v.op; e.rdata = v.exp_rdata; e.mis = v.exp_mis;
    sb.push_back(e);
    if (v.bus) begin
      chk({tag, "_dreq_valid"},  64'(dreq_valid),  64'd1);
      chk({tag, "_out_valid0"},  64'(out_valid),   64'd0);
      chk({tag, "_dreq_addr"},   dreq_addr,        v.addr);
      chk({tag, "_dreq_size"},   64'(dreq_size),   64'(v.size));
      chk({tag, "_dreq_strobe"}, 64'(dreq_strobe), 64'(v.strobe));
      chk({tag, "_dreq_data"},   dreq_data,        v.ddata);
      for (int i = 0; i < v.delay; i++) begin
        step();
        chk({tag, "_wait_dreq"}, 64'(dreq_valid), 64'd1);
        chk({tag, "_wait_out"},  64'(out_valid),  64'd0);
      end
      dresp_data_ok = 1'b1;
      dresp_data    = v.rdata;
      step();
      dresp_data_ok = 1'b0;
      dresp_data    = ~v.rdata;
      chk({tag, "_out_valid"},  64'(out_valid),  64'd1);
      chk({tag, "_dreq_drop"},  64'(dreq_valid), 64'd0);
    end else begin
      chk({tag, "_no_dreq"},    64'(dreq_valid), 64'd0);
      chk({tag, "_out_valid"},  64'(out_valid),  64'd1);
    end
    for (int h = 0; h < v.hold; h++) begin
      chk({tag, "_hold_in_ready"}, 64'(in_ready),  64'd0);
      chk({tag, "_hold_valid"},    64'(out_valid), 64'd1);
      chk({tag, "_hold_op"},       64'(out_op),    64'(v.op));
      chk({tag, "_hold_rdata"},    mem_rdata,      v.exp_rdata);
      chk({tag, "_hold_mis"},      64'(misalign),  64'(v.exp_mis));
      step();
    end
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_out_op"},    64'(out_op),   64'(e.op));
      chk({tag, "_mem_rdata"}, mem_rdata,     e.rdata);
      chk({tag, "_misalign"},  64'(misalign), 64'(e.mis));
    end
    step();
    out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_in_ready"},  64'(in_ready),  64'd1);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_wdata = '0;
    out_ready = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;

    //          op      addr                    wdata                 rdata                 dly hold bus size  strobe ddata                 exp_rdata             mis
    vecs.push_back(mk(OP_LW,  64'h0000_0040_0000_1004, 64'h0, 64'h8000_0000_0000_0000, 3, 0, 1, 3'd2, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0));
    vecs.push_back(mk(OP_LBU, 64'h0000_0040_0000_0007, 64'h0, 64'hAB00_0000_0000_0000, 0, 0, 1, 3'd0, 8'h00, 64'h0, 64'h0000_0000_0000_00AB, 1'b0));
    vecs.push_back(mk(OP_SH,  64'h0000_0040_0000_0006, 64'h1234, 64'h5555_5555_5555_5555, 1, 0, 1, 3'd1, 8'hC0, 64'h1234_0000_0000_0000, 64'h0, 1'b0));
    vecs.push_back(mk(OP_LD,  64'h0000_0040_0000_0004, 64'h0, 64'h0, 0, 0, 0, 3'd3, 8'h00, 64'h0, 64'h0, 1'b1));
    vecs.push_back(mk(OP_LB,  64'h0000_0040_0000_0003, 64'h0, 64'h0000_0000_8000_0000, 1, 0, 1, 3'd0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0));
    vecs.push_back(mk(OP_LH,  64'h0000_0040_0000_0002, 64'h0, 64'h0000_0000_8001_0000, 0, 0, 1, 3'd1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0));
    vecs.push_back(mk(OP_LHU, 64'h0000_0040_0000_0002, 64'h0, 64'h0000_0000_8001_0000, 2, 0, 1, 3'd1, 8'h00, 64'h0, 64'h0000_0000_0000_8001, 1'b0));
    vecs.push_back(mk(OP_LWU, 64'h0000_0040_0000_0000, 64'h0, 64'h1234_5678_F000_0000, 0, 0, 1, 3'd2, 8'h00, 64'h0, 64'h0000_0000_F000_0000, 1'b0));
    vecs.push_back(mk(OP_LD,  64'h0000_0040_0000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 5, 1, 3'd3, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0));
    vecs.push_back(mk(OP_SB,  64'h0000_0040_0000_0005, 64'hA5, 64'h0, 0, 0, 1, 3'd0, 8'h20, 64'h0000_A500_0000_0000, 64'h0, 1'b0));
    vecs.push_back(mk(OP_SW,  64'h0000_0040_0000_0004, 64'hCAFE_BABE, 64'h0, 1, 0, 1, 3'd2, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0, 1'b0));
    vecs.push_back(mk(OP_SD,  64'h0000_0040_0000_0000, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 1, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0));
    vecs.push_back(mk(OP_SW,  64'h0000_0040_0000_0002, 64'h1, 64'h0, 0, 2, 0, 3'd2, 8'h00, 64'h0, 64'h0, 1'b1));
    vecs.push_back(mk(OP_LH,  64'h0000_0040_0000_0001, 64'h0, 64'h0, 0, 0, 0, 3'd1, 8'h00, 64'h0, 64'h0, 1'b1));
    vecs.push_back(mk(OP_ALU, 64'h0000_0040_0000_0003, 64'h0, 64'h0, 0, 0, 0, 3'd0, 8'h00, 64'h0, 64'h0, 1'b0));
    vecs.push_back(mk(OP_LW,  64'h0000_0040_0000_0000, 64'h0, 64'hFFFF_FFFF_7FFF_FFFF, 0, 0, 1, 3'd2, 8'h00, 64'h0, 64'h0000_0000_7FFF_FFFF, 1'b0));
    vecs.push_back(mk(OP_LB,  64'h0000_0040_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FF7F, 0, 0, 1, 3'd0, 8'h00, 64'h0, 64'h0000_0000_0000_007F, 1'b0));

    // Reset state.
    repeat (3) step();
    chk("rst_in_ready",    64'(in_ready),    64'd1);
    chk("rst_out_valid",   64'(out_valid),   64'd0);
    chk("rst_dreq_valid",  64'(dreq_valid),  64'd0);
    chk("rst_mem_rdata",   mem_rdata,        64'd0);
    chk("rst_misalign",    64'(misalign),    64'd0);
    chk("rst_out_op",      64'(out_op),      64'(OP_NOP));
    chk("rst_dreq_addr",   dreq_addr,        64'd0);
    chk("rst_dreq_size",   64'(dreq_size),   64'd0);
    chk("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
    chk("rst_dreq_data",   dreq_data,        64'd0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset while a request is outstanding, then a stray completion.
    in_valid = 1'b1; in_op = OP_LW; in_addr = 64'h0000_0040_0000_0010; in_wdata = '0;
    step();
    in_valid = 1'b0; in_op = OP_NOP; in_addr = '0;
    chk("mid_dreq_valid", 64'(dreq_valid), 64'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("mid_rst_in_ready",   64'(in_ready),   64'd1);
    chk("mid_rst_out_valid",  64'(out_valid),  64'd0);
    dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    dresp_data_ok = 1'b0; dresp_data = '0;
    chk("stray_out_valid", 64'(out_valid), 64'd0);
    chk("stray_in_ready",  64'(in_ready),  64'd1);
    chk("stray_mem_rdata", mem_rdata,      64'd0);
    step();
    chk("stray_out_valid2", 64'(out_valid), 64'd0);

    // Recovery after reset.
    run_vec(vecs[1], 100);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
